fu_issue_sched: RTL and testbench
=================================

Name: fu_issue_sched

Overview:
- Schedules a shared fixed-latency multi-cycle functional unit between NREQ requesters.
- The unit is built around the team's ready/tag pipeline, whose ready output drops as soon as its input drops.
- The block grants one requester at a time using round-robin and holds the unit's start level and tag stable for the whole operation.
- It checks the returned ready/tag, then routes a one-cycle completion pulse back to the winning requester, with abort and timeout recovery.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 4, ce cycles from unit input high to unit ready high (pipeline stages + 1).
- WID, 6, tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ce_i  in  1  clock enable; when low, all state, counters and outputs hold.
- req_i  in  NREQ  per-requester level request; held until done or abandoned.
- id_i  in  NREQ*WID  per-requester tag; requester n uses bits [n*WID +: WID].
- gnt_o  out  NREQ  one-hot grant; held for the whole BUSY state.
- fu_go_o  out  1  drives the unit input; high only in BUSY.
- fu_id_o  out  WID  latched tag of the winner; drives the unit tag input.
- fu_rdy_i  in  1  unit ready output.
- fu_id_i  in  WID  unit tag output.
- done_o  out  NREQ  one-hot, one-cycle completion pulse.
- done_id_o  out  WID  tag accompanying done_o.
- abort_o  out  1  one-cycle pulse; the winner dropped req_i mid-operation.
- err_o  out  1  one-cycle pulse; timeout or tag mismatch.
- busy_o  out  1  high in BUSY or FLUSH.

Behaviour:
- Reset values: all outputs 0. State is IDLE. Round-robin pointer is 0. Cycle counter is 0.
- General: all registered outputs and state advance only on clock edges with ce_i=1.
- States: IDLE, BUSY, FLUSH.
- IDLE:
  - If any req_i bit is set, select the first set bit at or above the pointer, wrapping modulo NREQ.
  - Latch that requester's index and tag.
  - Next cycle: gnt_o one-hot, fu_go_o=1, fu_id_o=tag, counter=0, state BUSY.
  - If no request, stay in IDLE with outputs 0.
- BUSY: counter increments each ce cycle; it saturates and is wide enough to hold LATENCY+2. Conditions are evaluated in priority order:
  - 1) Winner's req_i=0: abort_o pulses next cycle; go to FLUSH; no done_o.
  - 2) fu_rdy_i=1 and fu_id_i==latched tag: done_o[winner]=1 and done_id_o=tag next cycle; go to FLUSH.
  - 3) fu_rdy_i=1 with fu_id_i mismatch: err_o pulses; go to FLUSH; no done_o.
  - 4) counter==LATENCY+2 with no ready: err_o pulses (timeout); go to FLUSH.
- FLUSH:
  - Lasts exactly one cycle, so the unit's ready pipeline clears.
  - fu_go_o=0, gnt_o=0.
  - Pointer becomes (winner+1) mod NREQ. This applies on completion, abort and error alike.
  - Then return to IDLE.
- Outputs by state:
  - fu_go_o, gnt_o and fu_id_o change only when entering or leaving BUSY.
  - fu_id_o returns to 0 in IDLE.
- Nominal latency:
  - Request seen in IDLE at cycle 0 gives grant in cycles 1..LATENCY+1.
  - fu_rdy_i is expected in cycle LATENCY+1, when the counter equals LATENCY.
  - done_o appears in cycle LATENCY+2, FLUSH is also LATENCY+2, and IDLE is LATENCY+3.
  - The next grant is visible at cycle LATENCY+4 at the earliest.
- done_o, abort_o and err_o are mutually exclusive single-cycle pulses, asserted in the FLUSH cycle.
- fu_rdy_i is ignored in IDLE and FLUSH; a spurious ready there has no effect.
- Requests from non-winners during BUSY are ignored and remain pending.
- ce_i=0 mid-operation freezes the counter and the state; pulses stretch until the next ce edge.
- Asserting rst_i mid-operation immediately drops fu_go_o and gnt_o to 0, with no done_o, abort_o or err_o.

Test Plan:
- Single request, LATENCY=4: req_i=0001, id=0x2A, with the unit modelled.
  - gnt_o=0001 and fu_go_o=1 in cycles 1-5.
  - done_o=0001 and done_id_o=0x2A in cycle 6.
  - busy_o falls in cycle 7.
- Round-robin fairness: req_i=1111 held continuously.
  - Grants arrive in the order 0001, 0010, 0100, 1000, 0001, each spaced LATENCY+3 cycles apart.
  - Pointer wraps from 3 to 0.
- Abort: requester 2 drops req in cycle 3.
  - abort_o in cycle 4; fu_go_o=0 in cycle 4; no done_o.
  - A following req_i=0001 is granted.
- Timeout: unit model never raises ready.
  - err_o pulses at cycle LATENCY+4=8; state returns to IDLE; the pointer advances.
- Tag mismatch: ready returns with tag 0x15 while 0x2A is latched.
  - err_o=1, done_o=0, next grant proceeds.
- ce gating and reset: ce_i low for 3 cycles mid-BUSY stretches done_o timing by exactly 3 cycles. rst_i pulsed mid-BUSY clears all outputs asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fu_issue_sched_if.sv
// Handshake bundle between the requesters/functional unit and the issue scheduler.
// The slave side is the scheduler; the master side is its environment.
interface fu_issue_sched_if #(
    parameter int NREQ = 4,
    parameter int WID  = 6
);
    logic                 ce_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*WID-1:0]  id_i;
    logic [NREQ-1:0]      gnt_o;
    logic                 fu_go_o;
    logic [WID-1:0]       fu_id_o;
    logic                 fu_rdy_i;
    logic [WID-1:0]       fu_id_i;
    logic [NREQ-1:0]      done_o;
    logic [WID-1:0]       done_id_o;
    logic                 abort_o;
    logic                 err_o;
    logic                 busy_o;

    modport slave (
        input  ce_i, req_i, id_i, fu_rdy_i, fu_id_i,
        output gnt_o, fu_go_o, fu_id_o, done_o, done_id_o, abort_o, err_o, busy_o
    );

    modport master (
        output ce_i, req_i, id_i, fu_rdy_i, fu_id_i,
        input  gnt_o, fu_go_o, fu_id_o, done_o, done_id_o, abort_o, err_o, busy_o
    );
endinterface

// File: rtl/fu_issue_sched.sv
// Round-robin issue scheduler for a shared fixed-latency functional unit.
// One requester owns the unit per operation; a one-cycle FLUSH lets the unit's ready clear.
module fu_issue_sched #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4,
    parameter int WID     = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    fu_issue_sched_if.slave bus
);
    localparam int CW = $clog2(LATENCY + 3);
    localparam int IW = $clog2(NREQ);
    localparam logic [CW-1:0] C_TMO = CW'(LATENCY + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [IW-1:0]   r_ptr, w_ptr_next;
    logic [IW-1:0]   r_win, w_win_next;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [WID-1:0]  r_tag, w_tag_next;
    logic [NREQ-1:0] r_done, w_done_next;
    logic [WID-1:0]  r_done_id, w_done_id_next;
    logic            r_abort, w_abort_next;
    logic            r_err, w_err_next;
    logic            w_go;
    logic [NREQ-1:0] w_win_onehot;
    logic [WID-1:0]  w_id_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_id_arr[gi]     = bus.id_i[gi*WID +: WID];
            assign w_win_onehot[gi] = (r_win == IW'(gi));
        end
    endgenerate

    // Scan downward so the lowest offset from the pointer is the one that sticks.
    always_comb begin
        int idx;
        idx    = 0;
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (bus.req_i[idx]) begin
                w_any  = 1'b1;
                w_pick = IW'(idx);
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ptr_next     = r_ptr;
        w_win_next     = r_win;
        w_cnt_next     = r_cnt;
        w_tag_next     = r_tag;
        w_done_next    = '0;
        w_done_id_next = '0;
        w_abort_next   = 1'b0;
        w_err_next     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next = S_BUSY;
                    w_win_next   = w_pick;
                    w_tag_next   = w_id_arr[w_pick];
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                if (r_cnt != C_TMO) w_cnt_next = r_cnt + CW'(1);
                if (!bus.req_i[r_win]) begin
                    w_abort_next = 1'b1;
                    w_state_next = S_FLUSH;
                end else if (bus.fu_rdy_i && (bus.fu_id_i == r_tag)) begin
                    w_done_next    = w_win_onehot;
                    w_done_id_next = r_tag;
                    w_state_next   = S_FLUSH;
                end else if (bus.fu_rdy_i || (r_cnt == C_TMO)) begin
                    w_err_next   = 1'b1;
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_next = S_IDLE;
                w_ptr_next   = (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_tag     <= '0;
            r_done    <= '0;
            r_done_id <= '0;
            r_abort   <= 1'b0;
            r_err     <= 1'b0;
        end else if (bus.ce_i) begin
            r_state   <= w_state_next;
            r_ptr     <= w_ptr_next;
            r_win     <= w_win_next;
            r_cnt     <= w_cnt_next;
            r_tag     <= w_tag_next;
            r_done    <= w_done_next;
            r_done_id <= w_done_id_next;
            r_abort   <= w_abort_next;
            r_err     <= w_err_next;
        end
    end

    // Unit drive is decoded straight from the state register so it only moves on BUSY entry/exit.
    assign w_go          = (r_state == S_BUSY);
    assign bus.fu_go_o   = w_go;
    assign bus.gnt_o     = w_go ? w_win_onehot : '0;
    assign bus.fu_id_o   = w_go ? r_tag : '0;
    assign bus.busy_o    = (r_state != S_IDLE);
    assign bus.done_o    = r_done;
    assign bus.done_id_o = r_done_id;
    assign bus.abort_o   = r_abort;
    assign bus.err_o     = r_err;
endmodule

// File: tb/tb_fu_issue_sched.sv
// Bench for fu_issue_sched: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_fu_issue_sched;
    localparam int NREQ    = 4;
    localparam int LATENCY = 4;
    localparam int WID     = 6;
    localparam int K_NONE = 0, K_DONE = 1, K_ABORT = 2, K_ERR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mode = 0;   // 0 normal unit, 1 never ready, 2 wrong tag, 3 spurious ready when idle
    int   u_cnt;

    always #5 clk = ~clk;

    fu_issue_sched_if #(.NREQ(NREQ), .WID(WID)) bus ();

    fu_issue_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .WID(WID)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Functional unit: ready after LATENCY enabled cycles of input high, drops with its input.
    always @(posedge clk or posedge rst) begin
        if (rst) u_cnt <= 0;
        else if (bus.ce_i) u_cnt <= bus.fu_go_o ? ((u_cnt < LATENCY) ? u_cnt + 1 : u_cnt) : 0;
    end
    assign bus.fu_rdy_i = (mode == 3) ? (!bus.fu_go_o || (u_cnt >= LATENCY))
                                      : ((mode != 1) && bus.fu_go_o && (u_cnt >= LATENCY));
    assign bus.fu_id_i  = (mode == 2) ? 6'h15 : bus.fu_id_o;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation record (owner, tag, age) plus its outcome.
    logic           m_active, m_flush;
    int             m_age, m_win, m_ptr, m_kind;
    logic [WID-1:0] m_tag;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_flush = 1'b0; m_age = 0; m_win = 0; m_ptr = 0;
            m_kind = K_NONE; m_tag = '0;
        end else if (bus.ce_i) begin
            if (m_flush) begin
                m_flush = 1'b0;
                m_kind  = K_NONE;
                m_ptr   = (m_win + 1) % NREQ;
            end else if (m_active) begin
                if (!bus.req_i[m_win])                           m_kind = K_ABORT;
                else if (bus.fu_rdy_i && bus.fu_id_i == m_tag)   m_kind = K_DONE;
                else if (bus.fu_rdy_i || m_age == LATENCY + 2)   m_kind = K_ERR;
                if (m_kind != K_NONE) begin
                    m_active = 1'b0;
                    m_flush  = 1'b1;
                    $display("txn %0t: requester %0d tag 0x%0h -> %s", $time, m_win, m_tag,
                             (m_kind == K_DONE) ? "done" : (m_kind == K_ABORT) ? "abort" : "error");
                end else begin
                    m_age++;
                end
            end else if (bus.req_i != '0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (bus.req_i[(m_ptr + k) % NREQ]) begin
                        m_win = (m_ptr + k) % NREQ;
                        break;
                    end
                end
                m_tag    = bus.id_i[m_win*WID +: WID];
                m_active = 1'b1;
                m_age    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_gnt",    64'(bus.gnt_o),   m_active ? 64'(1 << m_win) : 64'd0);
            chk("m_go",     64'(bus.fu_go_o), 64'(m_active));
            chk("m_fu_id",  64'(bus.fu_id_o), m_active ? 64'(m_tag) : 64'd0);
            chk("m_busy",   64'(bus.busy_o),  64'(m_active || m_flush));
            chk("m_done",   64'(bus.done_o),  (m_flush && m_kind == K_DONE) ? 64'(1 << m_win) : 64'd0);
            if (m_flush && m_kind == K_DONE) chk("m_done_id", 64'(bus.done_id_o), 64'(m_tag));
            chk("m_abort",  64'(bus.abort_o), 64'(m_flush && m_kind == K_ABORT));
            chk("m_err",    64'(bus.err_o),   64'(m_flush && m_kind == K_ERR));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.ce_i  = 1'b1;
        bus.req_i = '0;
        bus.id_i  = {6'h33, 6'h22, 6'h11, 6'h2A};
        cyc(2);
        chk("rst_gnt",  64'(bus.gnt_o),   64'd0);
        chk("rst_go",   64'(bus.fu_go_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o),  64'd0);
        chk("rst_done", 64'(bus.done_o),  64'd0);
        chk("rst_err",  64'(bus.err_o),   64'd0);
        rst = 1'b0;
        cyc(2);

        // Single request, nominal latency
        bus.req_i = 4'b0001;
        cyc(1); chk("s1_gnt_c1", 64'(bus.gnt_o), 64'h1); chk("s1_go_c1", 64'(bus.fu_go_o), 64'h1);
        cyc(4); chk("s1_gnt_c5", 64'(bus.gnt_o), 64'h1); chk("s1_go_c5", 64'(bus.fu_go_o), 64'h1);
        cyc(1); chk("s1_done_c6", 64'(bus.done_o), 64'h1); chk("s1_done_id_c6", 64'(bus.done_id_o), 64'h2A);
        chk("s1_gnt_c6", 64'(bus.gnt_o), 64'h0);
        bus.req_i = '0;
        cyc(1); chk("s1_busy_c7", 64'(bus.busy_o), 64'h0);

        // Round-robin with everyone requesting, pointer restarted by reset
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        cyc(1);
        bus.req_i = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cyc((g == 0) ? 1 : LATENCY + 3);
            chk($sformatf("rr_gnt_%0d", g), 64'(bus.gnt_o), 64'(1 << (g % 4)));
        end
        cyc(5); chk("rr_done_last", 64'(bus.done_o), 64'h1);
        bus.req_i = '0;
        cyc(2);

        // Abort by requester 2
        bus.req_i = 4'b0100;
        cyc(1); chk("ab_gnt_c1", 64'(bus.gnt_o), 64'h4);
        cyc(2); bus.req_i = '0;
        cyc(1); chk("ab_abort_c4", 64'(bus.abort_o), 64'h1); chk("ab_go_c4", 64'(bus.fu_go_o), 64'h0);
        chk("ab_done_c4", 64'(bus.done_o), 64'h0);
        bus.req_i = 4'b0001;
        cyc(2); chk("ab_next_gnt", 64'(bus.gnt_o), 64'h1);
        cyc(5); chk("ab_next_done", 64'(bus.done_o), 64'h1);
        bus.req_i = '0;
        cyc(2);

        // Timeout: unit never ready
        mode = 1;
        bus.req_i = 4'b0010;
        cyc(1); chk("to_gnt_c1", 64'(bus.gnt_o), 64'h2);
        cyc(6); chk("to_go_c7", 64'(bus.fu_go_o), 64'h1);
        cyc(1); chk("to_err_c8", 64'(bus.err_o), 64'h1); chk("to_done_c8", 64'(bus.done_o), 64'h0);
        bus.req_i = '0;
        mode = 0;
        cyc(1); chk("to_busy_c9", 64'(bus.busy_o), 64'h0);
        cyc(1);

        // Tag mismatch on requester 2 carrying 0x2A
        bus.id_i[2*WID +: WID] = 6'h2A;
        mode = 2;
        bus.req_i = 4'b0101;
        cyc(1); chk("mm_gnt_c1", 64'(bus.gnt_o), 64'h4); chk("mm_fu_id_c1", 64'(bus.fu_id_o), 64'h2A);
        cyc(5); chk("mm_err_c6", 64'(bus.err_o), 64'h1); chk("mm_done_c6", 64'(bus.done_o), 64'h0);
        bus.req_i = 4'b0001;
        mode = 0;
        cyc(2); chk("mm_next_gnt", 64'(bus.gnt_o), 64'h1);
        cyc(5); chk("mm_next_done", 64'(bus.done_o), 64'h1); chk("mm_next_done_id", 64'(bus.done_id_o), 64'h2A);
        bus.req_i = '0;
        cyc(2);

        // Clock-enable gating: 3 stalled cycles mid-BUSY, then a stretched done pulse
        bus.req_i = 4'b0010;
        cyc(2); bus.ce_i = 1'b0;
        cyc(3); bus.ce_i = 1'b1;
        cyc(1); chk("ce_done_c6", 64'(bus.done_o), 64'h0); chk("ce_go_c6", 64'(bus.fu_go_o), 64'h1);
        cyc(3); chk("ce_done_c9", 64'(bus.done_o), 64'h2); chk("ce_done_id_c9", 64'(bus.done_id_o), 64'h11);
        bus.ce_i = 1'b0;
        bus.req_i = '0;
        cyc(1); chk("ce_done_stretch", 64'(bus.done_o), 64'h2);
        cyc(1); bus.ce_i = 1'b1;
        cyc(1); chk("ce_busy_c12", 64'(bus.busy_o), 64'h0); chk("ce_done_c12", 64'(bus.done_o), 64'h0);

        // Spurious ready outside BUSY is ignored
        mode = 3;
        cyc(3); chk("sp_busy", 64'(bus.busy_o), 64'h0); chk("sp_err", 64'(bus.err_o), 64'h0);
        bus.req_i = 4'b0100;
        cyc(1); chk("sp_gnt_c1", 64'(bus.gnt_o), 64'h4);
        cyc(5); chk("sp_done_c6", 64'(bus.done_o), 64'h4);
        bus.req_i = '0;
        mode = 0;
        cyc(2);

        // Asynchronous reset mid-BUSY
        bus.req_i = 4'b1000;
        cyc(3); chk("rs_go_c3", 64'(bus.fu_go_o), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("rs_go_async",   64'(bus.fu_go_o), 64'h0);
        chk("rs_gnt_async",  64'(bus.gnt_o),   64'h0);
        chk("rs_busy_async", 64'(bus.busy_o),  64'h0);
        chk("rs_done_async", 64'(bus.done_o),  64'h0);
        bus.req_i = '0;
        #1 rst = 1'b0;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
